rf_writeback: RTL and testbench
===============================

// Module: rf_writeback
// PURPOSE
//  Write-side master for the 32x32 register file: drives its wa/wd/we port.
//  Merges single-cycle ALU results with multi-cycle LSU/MUL results, buffering the latter in a FIFO.
//  Keeps a busy scoreboard of pending multi-cycle destinations and flags read-after-write hazards.
//  Sits between the execute/memory stages and the register file.
// PARAMETERS
//  XLEN        32  data width of result/write port
//  AW          6   register address width (regfile port width; only 32 regs used)
//  FIFO_DEPTH  4   LSU result buffer entries, power of 2, >=2
// PORTS
//  clk         in   1     clock, rising edge
//  rst_n       in   1     asynchronous reset, active-low
//  alu_valid   in   1     ALU result present this cycle (no backpressure)
//  alu_rd      in   AW    ALU destination
//  alu_data    in   XLEN  ALU result
//  lsu_valid   in   1     LSU/MUL result offered
//  lsu_ready   out  1     FIFO can accept; transfer when valid&&ready
//  lsu_rd      in   AW    LSU destination
//  lsu_data    in   XLEN  LSU result
//  iss_valid   in   1     multi-cycle op issued this cycle
//  iss_rd      in   AW    its destination
//  chk_ra1     in   AW    decode-stage source 1
//  chk_ra2     in   AW    decode-stage source 2
//  hazard      out  1     source or iss_rd is busy -> decode must stall
//  alu_stall   out  1     FIFO full, upstream should insert ALU bubble
//  wa          out  AW    regfile write address
//  wd          out  XLEN  regfile write data
//  we          out  1     regfile write enable
// BEHAVIOUR
//  Reset (rst_n=0, async): we=0, wa=0, wd=0, busy[31:0]=0, FIFO empty; lsu_ready=1 after release.
//  wa/wd/we registered; one write per cycle.
//  Priority each cycle: alu_valid -> write ALU (latency 1); else FIFO non-empty -> pop head and write.
//  LSU path: every accepted result enters FIFO; min latency 2 cycles (push, then pop/write).
//  lsu_ready = (count != FIFO_DEPTH), from registered count; no same-cycle push when full even if popping.
//  alu_stall = (count == FIFO_DEPTH); if ALU still valid, ALU wins, FIFO holds.
//  Destination 0: we forced 0 for that slot; FIFO entry still popped; busy[0] never set.
//  Scoreboard: iss_valid && iss_rd!=0 sets busy[iss_rd]; LSU pop clears busy[rd] of popped entry.
//  Set and clear of same rd in one cycle: set wins.
//  hazard = busy[chk_ra1] | busy[chk_ra2] | (iss_valid & busy[iss_rd]); combinational; x0 never busy.
//  ALU write to a busy rd: written, busy unchanged (upstream must prevent WAW via hazard).
//  FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  Mid-operation reset: FIFO contents and busy bits discarded, we drops immediately.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined: adds outputs fwd1_hit/fwd1_data, fwd2_hit/fwd2_data (combinational):
//   hit when we && wa==chk_raN && wa!=0, data=wd; hazard then ignores a source whose busy bit
//   is being cleared by the write currently on wa/wd.
//  Undefined: no forwarding ports; regfile read-after-write goes through regfile only.
// STRUCTURE
//  Shared package rf_pkg: XLEN, AW, NREGS=32, typedef wb_entry_t {rd[AW], data[XLEN]}.
//  Sub-module rf_wb_fifo: sync FIFO of wb_entry_t, push/pop/full/empty/count.
//  Top holds arbiter, output registers, busy vector, hazard logic.
// TESTING
//  Reset: drive rst_n=0 mid-burst with 2 FIFO entries -> we=0, lsu_ready=1, hazard=0 next cycle.
//  ALU only: alu_rd=5, data=0xDEADBEEF -> next cycle we=1, wa=5, wd=0xDEADBEEF.
//  Contention: ALU valid 3 cycles, LSU rd=7 pushed cycle 0 -> LSU written cycle 4; busy[7] clears then.
//  Full: push 4 LSU results while ALU continuous -> lsu_ready=0, alu_stall=1; drop ALU 1 cycle -> 1 pop.
//  Scoreboard: iss rd=9, chk_ra1=9 -> hazard=1 until LSU rd=9 written; set+clear rd=9 same cycle -> stays busy.
//  x0: ALU rd=0 and LSU rd=0 -> we=0 both; FIFO drains; iss rd=0 -> hazard stays 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back slice.
//   XLEN   : result / write-port data width
//   AW     : register address width of the regfile port (only NREGS used)
//   NREGS  : architectural registers tracked by the busy scoreboard
//   wb_entry_t : one buffered multi-cycle result {rd, data}
package rf_pkg;
  localparam int XLEN  = 32;
  localparam int AW    = 6;
  localparam int NREGS = 32;
  localparam int RW    = $clog2(NREGS);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // Addresses beyond the architectural file are never considered busy.
  function automatic logic busy_of(logic [NREGS-1:0] busy, logic [AW-1:0] rd);
    logic hit;
    hit = 1'b0;
    if (rd < AW'(NREGS)) hit = busy[rd[RW-1:0]];
    return hit;
  endfunction

  function automatic logic tracked(logic [AW-1:0] rd);
    return (rd != '0) && (rd < AW'(NREGS));
  endfunction
endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of wb_entry_t buffering multi-cycle (LSU/MUL) results.
//   clk, rst_n     : clock, async active-low reset (clears pointers/count)
//   push, push_entry : write one entry (caller guarantees !full)
//   pop            : drop the head entry (caller guarantees !empty)
//   head           : current head entry (valid when !empty)
//   full, empty, count : occupancy, derived from the registered count
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  wb_entry_t     push_entry,
  input  logic          pop,
  output wb_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/rf_writeback.sv
// Write-side master of the 32x32 register file.
// Merges single-cycle ALU results with buffered multi-cycle LSU/MUL results,
// keeps a busy scoreboard of pending multi-cycle destinations and flags
// read-after-write hazards to decode.
// Optional feature macro: RF_WB_BYPASS_EN (adds fwd1_*/fwd2_* forwarding ports).
//   clk, rst_n          : clock, async active-low reset
//   alu_valid/rd/data   : ALU result, no backpressure, has write priority
//   lsu_valid/ready/rd/data : multi-cycle result, valid/ready handshake into FIFO
//   iss_valid, iss_rd   : multi-cycle op issue, marks iss_rd busy
//   chk_ra1, chk_ra2    : decode-stage sources checked against the scoreboard
//   hazard              : decode must stall
//   alu_stall           : FIFO full, upstream should insert an ALU bubble
//   wa, wd, we          : registered regfile write port
//   fwd1/2_hit, fwd1/2_data : (bypass build) forwarding of the current write
module rf_writeback
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   chk_ra1,
  input  logic [AW-1:0]   chk_ra2,
  output logic            hazard,
  output logic            alu_stall,
`ifdef RF_WB_BYPASS_EN
  output logic            fwd1_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd2_data,
`endif
  output logic [AW-1:0]   wa,
  output logic [XLEN-1:0] wd,
  output logic            we
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t        head;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic             iss_set;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Readiness comes from the registered count only: a full FIFO refuses a
  // push even in a cycle where it also pops.
  assign lsu_ready = !full;
  assign alu_stall = full;
  assign push      = lsu_valid && lsu_ready;
  assign pop       = !alu_valid && !empty;
  assign iss_set   = iss_valid && tracked(iss_rd);

  rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry ('{rd: lsu_rd, data: lsu_data}),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  // Write port: ALU first, otherwise FIFO head; x0 never asserts we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else if (alu_valid) begin
      we <= (alu_rd != '0);
      wa <= alu_rd;
      wd <= alu_data;
    end else if (pop) begin
      we <= (head.rd != '0);
      wa <= head.rd;
      wd <= head.data;
    end else begin
      we <= 1'b0;
    end
  end

  // Pop clears, issue sets afterwards so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (pop && tracked(head.rd)) busy_nxt[head.rd[RW-1:0]] = 1'b0;
    if (iss_set)                 busy_nxt[iss_rd[RW-1:0]]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

`ifdef RF_WB_BYPASS_EN
  // Marks that the write now on wa/wd came from a pop that really retired
  // the busy bit (not re-set by an issue to the same rd in that cycle).
  logic wb_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_clr <= 1'b0;
    else        wb_clr <= pop && !(iss_valid && iss_rd == head.rd);
  end

  assign fwd1_hit  = we && (wa == chk_ra1) && (wa != '0);
  assign fwd2_hit  = we && (wa == chk_ra2) && (wa != '0);
  assign fwd1_data = wd;
  assign fwd2_data = wd;

  assign hazard = (busy_of(busy, chk_ra1) && !(fwd1_hit && wb_clr))
                | (busy_of(busy, chk_ra2) && !(fwd2_hit && wb_clr))
                | (iss_valid && busy_of(busy, iss_rd));
`else
  assign hazard = busy_of(busy, chk_ra1)
                | busy_of(busy, chk_ra2)
                | (iss_valid && busy_of(busy, iss_rd));
`endif
endmodule

// File: tb/tb_rf_writeback.sv
// Directed self-checking bench for rf_writeback (default build).
module tb_rf_writeback;
  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [5:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [5:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        iss_valid;
  logic [5:0]  iss_rd;
  logic [5:0]  chk_ra1;
  logic [5:0]  chk_ra2;
  logic        hazard;
  logic        alu_stall;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic        we;
`ifdef RF_WB_BYPASS_EN
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
`endif

  int errors = 0;
  int checks = 0;

  rf_writeback #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_ra1   (chk_ra1),
    .chk_ra2   (chk_ra2),
    .hazard    (hazard),
    .alu_stall (alu_stall),
`ifdef RF_WB_BYPASS_EN
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
`endif
    .wa        (wa),
    .wd        (wd),
    .we        (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [5:0] ard; logic [31:0] ad;
    logic        lv;  logic [5:0] lrd; logic [31:0] ld;
    logic        iv;  logic [5:0] ird;
    logic [5:0]  c1;  logic [5:0] c2;
    logic        e_haz; logic e_rdy;
    logic        e_we;  logic [5:0] e_wa; logic [31:0] e_wd;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mkv(logic av, logic [5:0] ard, logic [31:0] ad,
                               logic lv, logic [5:0] lrd, logic [31:0] ld,
                               logic iv, logic [5:0] ird,
                               logic [5:0] c1, logic [5:0] c2,
                               logic e_haz, logic e_rdy,
                               logic e_we, logic [5:0] e_wa, logic [31:0] e_wd);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird; v.c1 = c1; v.c2 = c2;
    v.e_haz = e_haz; v.e_rdy = e_rdy;
    v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic av, logic [5:0] ard, logic [31:0] ad,
                       logic lv, logic [5:0] lrd, logic [31:0] ld,
                       logic iv, logic [5:0] ird, logic [5:0] c1, logic [5:0] c2);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    iss_valid = iv; iss_rd = ird; chk_ra1 = c1; chk_ra2 = c2;
  endtask

  task automatic idle(logic [5:0] c1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check a write landed (we/wa/wd) after the clock edge.
  task automatic check_wr(string nm, logic [5:0] e_wa, logic [31:0] e_wd);
    check({nm, ".we"}, {31'd0, we}, 32'd1);
    check({nm, ".wa"}, {26'd0, wa}, {26'd0, e_wa});
    check({nm, ".wd"}, wd, e_wd);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(0);
    #12;
    check("reset.we", {31'd0, we}, 32'd0);
    check("reset.wa", {26'd0, wa}, 32'd0);
    check("reset.wd", wd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("reset.lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("reset.hazard", {31'd0, hazard}, 32'd0);

    //                 av ard  ad            lv lrd ld        iv ird c1 c2 haz rdy we wa wd
    vecs[0]  = mkv(1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0,  0, 0, 0, 1, 1, 5, 32'hDEADBEEF);
    vecs[1]  = mkv(0, 0, 0,            0, 0, 0,        1, 9,  9, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mkv(0, 0, 0,            0, 0, 0,        0, 0,  9, 0, 1, 1, 0, 0, 0);
    vecs[3]  = mkv(0, 0, 0,            1, 9, 32'h99,   0, 0,  9, 0, 1, 1, 0, 0, 0);
    vecs[4]  = mkv(0, 0, 0,            0, 0, 0,        0, 0,  9, 0, 1, 1, 1, 9, 32'h99);
    vecs[5]  = mkv(0, 0, 0,            0, 0, 0,        0, 0,  9, 0, 0, 1, 0, 0, 0);
    vecs[6]  = mkv(0, 0, 0,            1, 9, 32'h55,   1, 9,  9, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mkv(0, 0, 0,            0, 0, 0,        1, 9,  9, 0, 1, 1, 1, 9, 32'h55);
    vecs[8]  = mkv(0, 0, 0,            0, 0, 0,        1, 9,  0, 0, 1, 1, 0, 0, 0);
    vecs[9]  = mkv(0, 0, 0,            1, 9, 32'h66,   0, 0,  0, 9, 1, 1, 0, 0, 0);
    vecs[10] = mkv(0, 0, 0,            0, 0, 0,        0, 0,  0, 9, 1, 1, 1, 9, 32'h66);
    vecs[11] = mkv(0, 0, 0,            0, 0, 0,        0, 0,  9, 9, 0, 1, 0, 0, 0);
    vecs[12] = mkv(1, 0, 32'h1,        1, 0, 32'h2,    1, 0,  0, 0, 0, 1, 0, 0, 0);
    vecs[13] = mkv(0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 0, 1, 0, 0, 0);
    vecs[14] = mkv(1, 3, 32'h33,       0, 0, 0,        0, 0,  9, 0, 0, 1, 1, 3, 32'h33);
    vecs[15] = mkv(0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld,
            vecs[i].iv, vecs[i].ird, vecs[i].c1, vecs[i].c2);
      #1;
      check($sformatf("vec%0d.hazard", i), {31'd0, hazard}, {31'd0, vecs[i].e_haz});
      check($sformatf("vec%0d.lsu_ready", i), {31'd0, lsu_ready}, {31'd0, vecs[i].e_rdy});
      check($sformatf("vec%0d.alu_stall", i), {31'd0, alu_stall}, {31'd0, !vecs[i].e_rdy});
      tick();
      check($sformatf("vec%0d.we", i), {31'd0, we}, {31'd0, vecs[i].e_we});
      if (vecs[i].e_we) begin
        check($sformatf("vec%0d.wa", i), {26'd0, wa}, {26'd0, vecs[i].e_wa});
        check($sformatf("vec%0d.wd", i), wd, vecs[i].e_wd);
      end
    end

    // Contention: LSU rd=7 pushed in cycle 0 behind three ALU writes.
    drive(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    tick();
    drive(1, 1, 32'h11, 1, 7, 32'h77, 0, 0, 7, 0);
    tick();
    check_wr("cont.c0", 1, 32'h11);
    drive(1, 2, 32'h22, 0, 0, 0, 0, 0, 7, 0);
    tick();
    check_wr("cont.c1", 2, 32'h22);
    drive(1, 3, 32'h33, 0, 0, 0, 0, 0, 7, 0);
    #1;
    check("cont.hazard_pending", {31'd0, hazard}, 32'd1);
    tick();
    check_wr("cont.c2", 3, 32'h33);
    idle(7);
    #1;
    check("cont.hazard_c3", {31'd0, hazard}, 32'd1);
    tick();
    check_wr("cont.c4_lsu", 7, 32'h77);
    check("cont.hazard_cleared", {31'd0, hazard}, 32'd0);

    // Full: four pushes behind continuous ALU traffic.
    for (int i = 0; i < 4; i++) begin
      drive(1, 4, i, 1, 6'(10 + i), 32'h100 + i, 0, 0, 0, 0);
      #1;
      check($sformatf("full.ready%0d", i), {31'd0, lsu_ready}, 32'd1);
      tick();
    end
    drive(1, 4, 32'h44, 1, 14, 32'h10E, 0, 0, 0, 0);
    #1;
    check("full.lsu_ready", {31'd0, lsu_ready}, 32'd0);
    check("full.alu_stall", {31'd0, alu_stall}, 32'd1);
    tick();
    check_wr("full.alu_wins", 4, 32'h44);
    drive(0, 0, 0, 1, 14, 32'h10E, 0, 0, 0, 0);
    #1;
    check("full.no_push_while_pop", {31'd0, lsu_ready}, 32'd0);
    tick();
    check_wr("full.one_pop", 10, 32'h100);
    drive(1, 4, 32'h45, 1, 14, 32'h10E, 0, 0, 0, 0);
    #1;
    check("full.ready_after_pop", {31'd0, lsu_ready}, 32'd1);
    check("full.stall_after_pop", {31'd0, alu_stall}, 32'd0);
    tick();
    check_wr("full.alu_again", 4, 32'h45);
    idle(0);
    tick();
    check_wr("full.drain0", 11, 32'h101);
    tick();
    check_wr("full.drain1", 12, 32'h102);
    tick();
    check_wr("full.drain2", 13, 32'h103);
    tick();
    check_wr("full.drain3", 14, 32'h10E);
    tick();
    check("full.empty_we", {31'd0, we}, 32'd0);

    // Reset mid-burst with two entries buffered and rd=20 busy.
    drive(1, 1, 32'hA1, 1, 21, 32'h21, 1, 20, 0, 0);
    tick();
    drive(1, 1, 32'hA2, 1, 22, 32'h22, 0, 0, 20, 0);
    #1;
    check("rst.hazard_before", {31'd0, hazard}, 32'd1);
    tick();
    check("rst.we_before", {31'd0, we}, 32'd1);
    idle(20);
    rst_n = 1'b0;
    #1;
    check("rst.we_async", {31'd0, we}, 32'd0);
    check("rst.hazard_async", {31'd0, hazard}, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst.we_after", {31'd0, we}, 32'd0);
    check("rst.lsu_ready_after", {31'd0, lsu_ready}, 32'd1);
    check("rst.hazard_after", {31'd0, hazard}, 32'd0);
    tick();
    check("rst.no_stale_pop", {31'd0, we}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
